// File: rtl/systolic_feed_sequencer.sv
// Feeds one tile of LENGTH operand rows into a systolic skew buffer, then drains it with zero rows.
// Optional SYSTOLIC_FEED_STALL_CNT_EN adds a saturating count of LOAD cycles without a valid row.
module systolic_feed_sequencer #(
    parameter int WIDTH        = 8,
    parameter int LENGTH       = 5,
    parameter int DRAIN_CYCLES = 2*LENGTH-1
) (
    input  logic                      CLK,
    input  logic                      ASYNC_RST,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LENGTH*WIDTH-1:0]   in_data,
    output logic                      setup_en,
    output logic                      setup_sync_rst,
    output logic [LENGTH*WIDTH-1:0]   setup_data,
    output logic                      busy,
    output logic                      done
`ifdef SYSTOLIC_FEED_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int MAX_CNT = (LENGTH > DRAIN_CYCLES) ? LENGTH : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(LENGTH - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, DONE, FLUSH} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   row_cnt_reg, row_cnt_next;
    logic [CNT_W-1:0]   drain_cnt_reg, drain_cnt_next;
    logic               pass_data;

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            state_reg     <= IDLE;
            row_cnt_reg   <= '0;
            drain_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            row_cnt_reg   <= row_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        row_cnt_next   = row_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        in_ready       = 1'b0;
        setup_en       = 1'b0;
        setup_sync_rst = 1'b0;
        pass_data      = 1'b0;
        busy           = (state_reg != IDLE);
        done           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                setup_sync_rst = 1'b1;
                row_cnt_next   = '0;
                state_next     = abort ? FLUSH : LOAD;
            end
            LOAD: begin
                // abort masks ready so a row offered in the same cycle is never consumed
                in_ready = ~abort;
                if (abort) begin
                    state_next = FLUSH;
                end else if (in_valid) begin
                    setup_en     = 1'b1;
                    pass_data    = 1'b1;
                    row_cnt_next = row_cnt_reg + CNT_W'(1);
                    if (row_cnt_reg == LAST_ROW) begin
                        state_next     = DRAIN;
                        drain_cnt_next = '0;
                    end
                end
            end
            DRAIN: begin
                setup_en = 1'b1;
                if (abort) begin
                    state_next = FLUSH;
                end else if (drain_cnt_reg == LAST_DRAIN) begin
                    state_next = DONE;
                end else begin
                    drain_cnt_next = drain_cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            FLUSH: begin
                setup_sync_rst = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Rows pass straight through; zero rows fill the pipeline outside accepted handshakes
    for (genvar gi = 0; gi < LENGTH; gi++) begin : g_lane
        assign setup_data[gi*WIDTH +: WIDTH] = pass_data ? in_data[gi*WIDTH +: WIDTH] : '0;
    end

`ifdef SYSTOLIC_FEED_STALL_CNT_EN
    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            stall_cnt <= '0;
        end else if (state_reg == CLEAR) begin
            stall_cnt <= '0;
        end else if (state_reg == LOAD && !in_valid && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// Bench for systolic_feed_sequencer: directed tile scenarios then random traffic, checked
// cycle by cycle against a tile-level reference model and an end-to-end latency formula.
module tb_systolic_feed_sequencer;

    localparam int W   = 8;
    localparam int LEN = 5;
    localparam int DRN = 2*LEN-1;
    localparam int DW  = LEN*W;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_LOAD  = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;
    localparam int P_FLUSH = 5;

    logic          CLK = 1'b0;
    logic          ASYNC_RST = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          setup_en;
    logic          setup_sync_rst;
    logic [DW-1:0] setup_data;
    logic          busy;
    logic          done;
`ifdef SYSTOLIC_FEED_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    systolic_feed_sequencer #(.WIDTH(W), .LENGTH(LEN), .DRAIN_CYCLES(DRN)) dut (
        .CLK            (CLK),
        .ASYNC_RST      (ASYNC_RST),
        .start          (start),
        .abort          (abort),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .setup_en       (setup_en),
        .setup_sync_rst (setup_sync_rst),
        .setup_data     (setup_data),
        .busy           (busy),
        .done           (done)
`ifdef SYSTOLIC_FEED_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = -1;
    int tiles = 0;

    // Reference model: tile phase plus rows still owed and drain cycles still owed
    int phase = P_IDLE, n_phase = P_IDLE;
    int rows_left = 0, n_rows_left = 0;
    int drain_left = 0, n_drain_left = 0;
    int stalls = 0, n_stalls = 0;
    int tile_start = 0;
    int tile_stalls = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] row(input int k);
        logic [DW-1:0] r;
        for (int l = 0; l < LEN; l++) r[l*W +: W] = W'(k*16 + l);
        return r;
    endfunction

    task automatic eval_cycle();
        bit hs;
        logic [DW-1:0] exp_data;
        hs       = (phase == P_LOAD) && !abort && in_valid;
        exp_data = hs ? in_data : '0;
        check("busy",     64'(busy),           64'(phase != P_IDLE));
        check("done",     64'(done),           64'(phase == P_DONE));
        check("sync_rst", 64'(setup_sync_rst), 64'(phase == P_CLEAR || phase == P_FLUSH));
        check("in_ready", 64'(in_ready),       64'(phase == P_LOAD && !abort));
        check("setup_en", 64'(setup_en),       64'(hs || phase == P_DRAIN));
        check("data",     64'(setup_data),     64'(exp_data));
`ifdef SYSTOLIC_FEED_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt),     64'(stalls));
`endif
        if (done === 1'b1)
            check("latency", 64'(cyc), 64'(tile_start + 2 + LEN + DRN + tile_stalls));

        n_phase = phase; n_rows_left = rows_left; n_drain_left = drain_left; n_stalls = stalls;
        if (ASYNC_RST) begin
            n_phase = P_IDLE; n_rows_left = 0; n_drain_left = 0; n_stalls = 0;
            return;
        end
        case (phase)
            P_IDLE: if (start) begin
                n_phase = P_CLEAR; tile_start = cyc; tile_stalls = 0;
            end
            P_CLEAR: begin
                n_stalls = 0;
                n_phase = abort ? P_FLUSH : P_LOAD;
                n_rows_left = LEN;
            end
            P_LOAD: begin
                if (!in_valid && stalls < 65535) n_stalls = stalls + 1;
                if (!in_valid) tile_stalls++;
                if (abort) n_phase = P_FLUSH;
                else if (hs) begin
                    n_rows_left = rows_left - 1;
                    if (n_rows_left == 0) begin n_phase = P_DRAIN; n_drain_left = DRN; end
                end
            end
            P_DRAIN: begin
                if (abort) n_phase = P_FLUSH;
                else begin
                    n_drain_left = drain_left - 1;
                    if (n_drain_left == 0) n_phase = P_DONE;
                end
            end
            P_DONE: begin
                tiles++;
                $display("tile %0d done at cycle %0d (started %0d, stalls %0d)", tiles, cyc, tile_start, tile_stalls);
                n_phase = P_IDLE;
            end
            default: begin
                tiles++;
                $display("tile %0d flushed at cycle %0d", tiles, cyc);
                n_phase = P_IDLE;
            end
        endcase
    endtask

    task automatic run_cycle(input bit st, input bit ab, input bit iv, input logic [DW-1:0] d, input bit rs);
        @(posedge CLK);
        phase = n_phase; rows_left = n_rows_left; drain_left = n_drain_left; stalls = n_stalls;
        cyc++;
        #1;
        start = st; abort = ab; in_valid = iv; in_data = d; ASYNC_RST = rs;
        if (rs) begin
            phase = P_IDLE; rows_left = 0; drain_left = 0; stalls = 0;
            $display("reset pulse at cycle %0d", cyc);
        end
        @(negedge CLK);
        eval_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, 0, 0, '0, 0);
    endtask

    task automatic nominal_tile();
        run_cycle(1, 0, 0, '0, 0);
        run_cycle(0, 0, 1, row(1), 0);
        for (int k = 1; k <= LEN; k++) run_cycle(0, 0, 1, row(k), 0);
    endtask

    initial begin
        #2;
        check("rst_busy",  64'(busy),       64'(0));
        check("rst_en",    64'(setup_en),   64'(0));
        check("rst_ready", 64'(in_ready),   64'(0));
        check("rst_data",  64'(setup_data), 64'(0));

        // nominal tile
        nominal_tile();
        idle(12);
        // three stall cycles after row 2
        run_cycle(1, 0, 0, '0, 0);
        run_cycle(0, 0, 1, row(1), 0);
        run_cycle(0, 0, 1, row(1), 0);
        run_cycle(0, 0, 1, row(2), 0);
        for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, row(9), 0);
        for (int k = 3; k <= LEN; k++) run_cycle(0, 0, 1, row(k), 0);
        idle(13);
        // abort while row 3 is offered
        run_cycle(1, 0, 0, '0, 0);
        run_cycle(0, 0, 1, row(1), 0);
        run_cycle(0, 0, 1, row(1), 0);
        run_cycle(0, 0, 1, row(2), 0);
        run_cycle(0, 1, 1, row(3), 0);
        idle(3);
        // reset during DRAIN, then a clean tile
        nominal_tile();
        idle(3);
        run_cycle(0, 0, 0, '0, 1);
        idle(2);
        nominal_tile();
        idle(12);
        // start held continuously
        for (int i = 0; i < 40; i++) run_cycle(1, 0, 1, DW'({$urandom, $urandom}), 0);
        idle(20);
        // abort alone in IDLE, abort with start, abort in DONE
        run_cycle(0, 1, 0, '0, 0);
        run_cycle(1, 1, 1, row(1), 0);
        for (int c = 1; c <= 16; c++) run_cycle(0, (c == 16), 1, row(c), 0);
        idle(3);
        // random traffic
        for (int i = 0; i < 3000; i++)
            run_cycle($urandom_range(3) == 0, $urandom_range(39) == 0, $urandom_range(3) != 0,
                      DW'({$urandom, $urandom}), $urandom_range(299) == 0);
        idle(25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
